// File: rtl/pheap_lvl_mem_pkg.sv
// Shared types for the pipelined heap: entry layout, empty constants and the
// level-memory init helpers.
package pheap_lvl_mem_pkg;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;
    localparam int CAP_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    typedef struct packed {
        logic             active;
        logic [CAP_W-1:0] capacity;
        kv_t              kv;
    } entry_t;

    localparam kv_t    KV_EMPTY    = '{key: '1, val: '0};
    localparam entry_t ENTRY_EMPTY = '{active: 1'b0, capacity: '0, kv: KV_EMPTY};

    typedef enum logic {INIT, RUN} lvlmem_state_t;

    // Free slots in a full subtree rooted at this level.
    function automatic int unsigned cap_init(int unsigned level, int unsigned nlevels);
        return (32'd1 << (nlevels - level + 1)) - 1;
    endfunction

    function automatic entry_t entry_init(int unsigned level, int unsigned nlevels);
        entry_t e;
        e          = ENTRY_EMPTY;
        e.capacity = CAP_W'(cap_init(level, nlevels));
        return e;
    endfunction

endpackage

// File: rtl/pheap_lvl_mem_if.sv
// Controller-side bus of one heap level memory: top read/write plus the
// parent's child-pair read.
interface pheap_lvl_mem_if #(parameter int LEVEL = 2) ();
    import pheap_lvl_mem_pkg::*;

    localparam int AW = LEVEL - 1;

    logic [AW-1:0] raddrTop;
    entry_t        rTop;
    logic [AW-1:0] raddrBot;
    entry_t        rBotL;
    entry_t        rBotR;
    logic          wenTop;
    logic [AW-1:0] wraddrTop;
    entry_t        wData;
    logic          ready;

    modport master (
        output raddrTop, raddrBot, wenTop, wraddrTop, wData,
        input  rTop, rBotL, rBotR, ready
    );

    modport slave (
        input  raddrTop, raddrBot, wenTop, wraddrTop, wData,
        output rTop, rBotL, rBotR, ready
    );

endinterface

// File: rtl/pheap_lvl_mem_rdport.sv
// One registered read port with same-cycle write forwarding and an init
// override that forces the reset entry while the array is being swept.
module pheap_fwd_rdport
    import pheap_lvl_mem_pkg::*;
#(
    parameter int     AW       = 1,
    parameter entry_t INIT_VAL = ENTRY_EMPTY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic [AW-1:0] i_raddr,
    input  entry_t        i_mem,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    output entry_t        o_data
);

    entry_t r_data;

    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_data <= INIT_VAL;
        end else if (i_wen && (i_waddr == i_raddr)) begin
            r_data <= i_wdata;
        end else begin
            r_data <= i_mem;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pheap_lvl_mem.sv
// Storage for one heap level (LEVEL >= 2): self-initialising entry array with
// a top read/write port and the parent's child-pair read port.
module pheap_lvl_mem
    import pheap_lvl_mem_pkg::*;
#(
    parameter int LEVEL   = 2,
    parameter int NLEVELS = 4
) (
    input  logic            clk,
    input  logic            rst,
    pheap_lvl_mem_if.slave  bus
);

    localparam int     AW    = LEVEL - 1;
    localparam int     DEPTH = 1 << AW;
    localparam entry_t EI    = entry_init(LEVEL, NLEVELS);

    if (LEVEL < 2 || LEVEL > NLEVELS) begin : g_bad_level
        $error("pheap_lvl_mem: LEVEL out of range 2..NLEVELS");
    end
    if (cap_init(LEVEL, NLEVELS) > (2 ** CAP_W) - 1) begin : g_bad_cap
        $error("pheap_lvl_mem: initial capacity overflows entry_t capacity field");
    end

    lvlmem_state_t r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_ready, w_ready_nxt;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    entry_t        w_wdata;
    logic [AW-1:0] w_bot_l, w_bot_r;
    logic          w_init;
    entry_t        r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        w_we        = 1'b0;
        w_waddr     = bus.wraddrTop;
        w_wdata     = bus.wData;
        case (r_state)
            INIT: begin
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_wdata   = EI;
                w_ptr_nxt = r_ptr + AW'(1);
                if (r_ptr == '1) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            RUN: begin
                w_we = bus.wenTop;
            end
            default: w_state_nxt = INIT;
        endcase
        if (rst) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Child pair is always {even, even|1}, so the odd address cannot wrap.
    assign w_bot_l   = bus.raddrBot & ~AW'(1);
    assign w_bot_r   = w_bot_l | AW'(1);
    assign w_init    = (r_state == INIT);
    assign bus.ready = r_ready;

    pheap_fwd_rdport #(.AW(AW), .INIT_VAL(EI)) u_rd_top (
        .clk(clk), .rst(rst), .i_init(w_init), .i_raddr(bus.raddrTop),
        .i_mem(r_mem[bus.raddrTop]), .i_wen(bus.wenTop), .i_waddr(bus.wraddrTop),
        .i_wdata(bus.wData), .o_data(bus.rTop)
    );

    pheap_fwd_rdport #(.AW(AW), .INIT_VAL(EI)) u_rd_botl (
        .clk(clk), .rst(rst), .i_init(w_init), .i_raddr(w_bot_l),
        .i_mem(r_mem[w_bot_l]), .i_wen(bus.wenTop), .i_waddr(bus.wraddrTop),
        .i_wdata(bus.wData), .o_data(bus.rBotL)
    );

    pheap_fwd_rdport #(.AW(AW), .INIT_VAL(EI)) u_rd_botr (
        .clk(clk), .rst(rst), .i_init(w_init), .i_raddr(w_bot_r),
        .i_mem(r_mem[w_bot_r]), .i_wen(bus.wenTop), .i_waddr(bus.wraddrTop),
        .i_wdata(bus.wData), .o_data(bus.rBotR)
    );

endmodule

// File: tb/tb_pheap_lvl_mem.sv
// Scoreboard bench for pheap_lvl_mem at LEVEL=3, NLEVELS=4: directed scenarios
// followed by randomized traffic against an array-based reference model.
module tb_pheap_lvl_mem;
    import pheap_lvl_mem_pkg::*;

    localparam int LEVEL   = 3;
    localparam int NLEVELS = 4;
    localparam int AW      = LEVEL - 1;
    localparam int DEPTH   = 4;

    typedef struct {
        entry_t top;
        entry_t l;
        entry_t r;
        logic   rdy;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    entry_t EI;
    entry_t m_mem [DEPTH];
    int unsigned m_n = 0;
    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;

    pheap_lvl_mem_if #(.LEVEL(LEVEL)) bus ();

    pheap_lvl_mem #(.LEVEL(LEVEL), .NLEVELS(NLEVELS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(logic a, logic [7:0] cap, logic [7:0] key);
        entry_t e;
        e.active   = a;
        e.capacity = cap;
        e.kv.key   = key;
        e.kv.val   = 8'h00;
        return e;
    endfunction

    function automatic entry_t rnd_entry();
        logic [$bits(entry_t)-1:0] x;
        x = $bits(entry_t)'($urandom);
        return entry_t'(x);
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic step(input logic r, input logic w, input int unsigned wa, input entry_t wd,
                        input int unsigned ra, input int unsigned rb);
        exp_t e;
        int unsigned bl, br;
        @(negedge clk);
        rst           = r;
        bus.wenTop    = w;
        bus.wraddrTop = AW'(wa);
        bus.wData     = wd;
        bus.raddrTop  = AW'(ra);
        bus.raddrBot  = AW'(rb);
        if (r) begin
            e   = '{EI, EI, EI, 1'b0};
            m_n = 0;
        end else if (m_n < DEPTH) begin
            e = '{EI, EI, EI, (m_n == DEPTH - 1)};
            if (m_n == DEPTH - 1)
                for (int i = 0; i < DEPTH; i++) m_mem[i] = EI;
            m_n++;
        end else begin
            bl    = (rb / 2) * 2;
            br    = bl + 1;
            e.top = (w && wa == ra) ? wd : m_mem[ra];
            e.l   = (w && wa == bl) ? wd : m_mem[bl];
            e.r   = (w && wa == br) ? wd : m_mem[br];
            e.rdy = 1'b1;
            if (w) m_mem[wa] = wd;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input entry_t act, input entry_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rTop", bus.rTop, e.top);
                chk("rBotL", bus.rBotL, e.l);
                chk("rBotR", bus.rBotR, e.r);
                checks++;
                if (bus.ready !== e.rdy) begin
                    errors++;
                    $display("FAIL ready: got %b expected %b at %0t", bus.ready, e.rdy, $time);
                end
            end
        end
    end

    initial begin : stim
        entry_t z;
        EI = mk(1'b0, 8'((2 ** (NLEVELS - LEVEL + 1)) - 1), 8'hFF);
        z  = mk(1'b0, 8'd0, 8'd0);
        bus.wenTop    = 1'b0;
        bus.wraddrTop = '0;
        bus.wData     = z;
        bus.raddrTop  = '0;
        bus.raddrBot  = '0;

        // reset, then INIT with a write attempt that must be discarded
        step(1, 0, 0, z, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, mk(1, 8'd1, 8'h7F), i, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, z, i, i);

        // write then read back
        step(0, 1, 2, mk(1, 8'd2, 8'h10), 1, 0);
        step(0, 0, 0, z, 2, 2);
        step(0, 0, 0, z, 1, 0);

        // forwarding on top and odd child
        step(0, 1, 1, mk(1, 8'd2, 8'h22), 1, 0);
        step(0, 0, 0, z, 1, 1);

        // child pair via even and odd base address
        step(0, 1, 2, mk(1, 8'd1, 8'h05), 0, 0);
        step(0, 1, 3, mk(1, 8'd1, 8'h09), 0, 0);
        step(0, 0, 0, z, 3, 2);
        step(0, 0, 0, z, 2, 3);

        // reset mid-RUN with a concurrent write
        step(1, 1, 0, mk(1, 8'd3, 8'h55), 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, z, i, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, z, i, 3 - i);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, DEPTH - 1), rnd_entry(),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
        end

        @(negedge clk);
        bus.wenTop = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
